w_mem_read_streamer: RTL and testbench
======================================

# w_mem_read_streamer

Read-side initiator for the weight SRAM wrapper: on a start pulse, it issues a burst of sequential word reads (base address, length) on the wrapper's `rd_enable`/`rd_addr` port. It captures the one-cycle-latency `rd_data` returns into a 2-entry skid FIFO and presents them to the PE-array weight loader as a valid/ready stream. It sits between the layer controller (start/done) and the weight memory wrapper, and yields the SRAM to the writer whenever a write is active.

## Interface
- `ADDR_W`, 15, total weight-memory word address width; matches the wrapper's `SRAM_totalWordAddr`.
- `DATA_W`, 32, read data width (`SRAM_blocks_per_row * SRAM_numBit`).
- `LEN_W`, `ADDR_W+1`, burst length counter width, so a full-memory burst is expressible.
- `FIFO_DEPTH`, 2, skid FIFO entries; fixed at 2 and not intended to be overridden.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle pulse that launches a burst; ignored while `busy`=1.
- `base_addr` in `ADDR_W`: first word address, sampled on an accepted `start`.
- `length` in `LEN_W`: number of words, sampled on an accepted `start`.
- `wr_active` in 1: the writer drives `wr_enable` this cycle, so no read may issue.
- `rd_enable` out 1: read strobe to the wrapper.
- `rd_addr` out `ADDR_W`: read address to the wrapper.
- `rd_data` in `DATA_W`: wrapper read data, valid one cycle after `rd_enable`.
- `out_data` out `DATA_W`: head of the FIFO.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts `out_data` when `out_valid`=1.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse when the last word of a burst is popped.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
  - IDLE with `start`: latch `base_addr` into `addr_q` and `length` into `remain_q`, and set `busy`=1.
    - If `length`=0, go straight to DRAIN.
    - Otherwise go to ISSUE.
  - ISSUE: issue one read per cycle while the issue condition holds.
    - Each issue increments `addr_q` modulo 2^`ADDR_W`; wrap-around is legal and silent.
    - Each issue decrements `remain_q`.
    - When the last read issues, go to DRAIN.
  - DRAIN: wait until `inflight_q`=0 and the FIFO is empty, then pulse `done`, set `busy`=0 and return to IDLE.
- Issue condition: `state`==ISSUE && `wr_active`==0 && (`count_q` + `inflight_q` − pop) < 2, where pop = `out_valid` & `out_ready`.
  - `rd_enable` is combinational from this condition; `rd_addr` = `addr_q`.
  - When `rd_enable`=0, `rd_addr` holds `addr_q` and does not toggle.
- `inflight_q` is 1 bit. It is set on an issue and cleared the next cycle. The returning `rd_data` is pushed into the FIFO on the cycle `inflight_q`=1.
- The FIFO supports simultaneous push and pop; count is unchanged. The credit rule makes overflow impossible; overflow is an assertion failure.
- A `start` while `busy`=1 is dropped; there is no queuing.
- `done` for a zero-length burst asserts 2 cycles after `start` (IDLE→DRAIN→IDLE).
- Reset mid-burst: all state clears, in-flight data is discarded and no `done` is produced.

## Timing
- Reset values: `rd_enable`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0; the FSM is in IDLE.
- `start` in cycle T → first `rd_enable` in cycle T+1 (when `wr_active`=0) → data in `rd_data` at T+2 → `out_valid` at T+3.
- With `out_ready` held at 1 and no `wr_active`, throughput is 1 word per cycle. An N-word burst has `done` at T+N+3.
- `out_valid`/`out_data` are registered. `out_data` must stay stable while `out_valid`=1 && `out_ready`=0.
- There is a combinational path from `out_ready` and `wr_active` to `rd_enable`. This is accepted; both inputs are early-cycle registered signals.

## Structure
- The shared params package holds:
  - the FSM enum `w_rd_state_t` (IDLE, ISSUE, DRAIN);
  - the weight address width, derived from the macro word count (512), word bits (32), 2 block columns and 4 subblocks;
  - `DATA_W`.
- One sub-module, `w_rd_skid_fifo`: 2-entry, `DATA_W`-wide, registered output, with push/pop/count. The top level contains the FSM, the address/length counters and the credit logic.

## Test plan
- Basic burst: `base_addr`=0x0010, `length`=8, `out_ready`=1 → `rd_addr` 0x10..0x17 on consecutive cycles; `out_data` equals the preloaded words in order; `done` at `start`+11.
- Backpressure: `length`=6, `out_ready` toggles 1,0,0,1 repeating → no word lost or duplicated; `rd_enable` never makes `count`+`inflight` exceed 2; `out_data` stable while stalled.
- Write priority: `wr_active`=1 for cycles 2–4 of a 5-word burst → no `rd_enable` in those cycles; addresses resume in sequence afterwards; all 5 words are delivered.
- Wrap and zero length:
  - `base_addr`=0x7FFE, `length`=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
  - `length`=0 → no `rd_enable`; `done` exactly 2 cycles after `start`.
- Reset and ignored start:
  - `reset` low after 3 of 10 words → all outputs return to 0 immediately; no `done`.
  - A `start` pulse while `busy`=1 → ignored; the burst completes with its original parameters.

Source files
------------

// File: rtl/w_mem_read_streamer_pkg.sv
// Shared widths and FSM encoding for the weight-memory read streamer.
package w_mem_read_streamer_pkg;

  localparam int unsigned MACRO_WORDS = 512;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned BLOCK_COLS  = 2;
  localparam int unsigned SUBBLOCKS   = 4;

  // Total weight-memory word address width (matches the wrapper's total word address)
  localparam int unsigned ADDR_W =
    $clog2(MACRO_WORDS * BLOCK_COLS * SUBBLOCKS * (WORD_BITS / SUBBLOCKS));
  localparam int unsigned DATA_W     = WORD_BITS;
  localparam int unsigned LEN_W      = ADDR_W + 1;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } w_rd_state_t;

endpackage

// File: rtl/w_rd_skid_fifo.sv
// Two-entry skid FIFO with registered head/valid; push and pop may coincide.
module w_rd_skid_fifo
  import w_mem_read_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] head_q, head_n;
  logic [DATA_W-1:0] tail_q, tail_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              valid_q;

  // Next head/tail/count from the push/pop combination
  always_comb begin
    head_n  = head_q;
    tail_n  = tail_q;
    count_n = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == '0) head_n = din;
        else               tail_n = din;
        count_n = count_q + CNT_W'(1);
      end
      2'b01: begin
        head_n  = tail_q;
        count_n = count_q - CNT_W'(1);
      end
      2'b11: begin
        if (count_q == CNT_W'(1)) begin
          head_n = din;
        end else begin
          head_n = tail_q;
          tail_n = din;
        end
      end
      default: ;
    endcase
  end

  // Storage and registered valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      valid_q <= (count_n != '0);
    end
  end

  assign dout  = head_q;
  assign valid = valid_q;
  assign count = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
    !(pop && count_q == '0));

endmodule

// File: rtl/w_mem_read_streamer.sv
// Burst read initiator for the weight SRAM: issues sequential reads under a
// two-word credit and streams the returned words out via a skid FIFO.
module w_mem_read_streamer
  import w_mem_read_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              wr_active,
  output logic              rd_enable,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OCC_W = CNT_W + 1;

  w_rd_state_t       state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0]  remain_q, remain_n;
  logic              inflight_q;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic [OCC_W-1:0]  occ;
  logic              credit_ok;
  logic              issue;

  assign pop       = out_valid & out_ready;
  assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  // At most two words may be buffered or in flight after this cycle's pop
  assign credit_ok = occ < (OCC_W'(2) + OCC_W'(pop));
  assign issue     = (state_q == ISSUE) && !wr_active && credit_ok;

  // Next-state, counters and done/busy
  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    remain_n = remain_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_n   = base_addr;
          remain_n = length;
          busy_n   = 1'b1;
          state_n  = (length == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_n   = addr_q + ADDR_W'(1);
          remain_n = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        // Finish on the cycle the final word leaves, so done lands right after
        if (!inflight_q &&
            ((fifo_count == '0) || (fifo_count == CNT_W'(1) && pop))) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and the one-cycle read-latency tracker
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      addr_q     <= addr_n;
      remain_q   <= remain_n;
      inflight_q <= issue;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  w_rd_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   (rd_data),
    .dout  (out_data),
    .valid (out_valid),
    .count (fifo_count)
  );

  assign rd_enable = issue;
  assign rd_addr   = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_w_mem_read_streamer.sv
// Bench for w_mem_read_streamer: table of bursts plus random bursts, checked
// against a word-queue model of what the consumer must receive.
module tb_w_mem_read_streamer;
  import w_mem_read_streamer_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              wr_active;
  logic              rd_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  w_mem_read_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .wr_active (wr_active),
    .rd_enable (rd_enable),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = {17'h0, a};
    return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM wrapper model: one-cycle read latency, garbage when not reading
  always @(posedge clk) rd_data <= rd_enable ? word_of(rd_addr) : 32'hDEAD_BEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model state
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] next_addr;
  int                issues_left = 0;
  int                issued = 0;
  int                popped = 0;
  int                cur_len = -1;
  int                exp_done_cyc = -1;
  int                done_cyc = -1;
  bit                stalled_prev = 0;
  logic [DATA_W-1:0] held;

  task automatic monitor();
    logic [DATA_W-1:0] e;
    bit exp_done;
    if (stalled_prev)
      chk("stall_hold", out_valid && out_data == held, {31'b0, out_valid, out_data}, {32'h1, held});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 1'b0, 64'(out_data), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data == e, 64'(out_data), 64'(e));
      end
      popped++;
      if (popped == cur_len) exp_done_cyc = cyc + 1;
    end
    if (rd_enable) begin
      chk("wr_priority", !wr_active, 64'(wr_active), 64'(0));
      chk("rd_addr", issues_left > 0 && rd_addr == next_addr, 64'(rd_addr), 64'(next_addr));
      exp_q.push_back(word_of(next_addr));
      next_addr = next_addr + ADDR_W'(1);
      issues_left--;
      issued++;
      chk("credit", (issued - popped) <= 2, 64'(issued - popped), 64'(2));
    end
    exp_done = (cyc == exp_done_cyc);
    chk("done", done == exp_done, 64'(done), 64'(exp_done));
    if (done) done_cyc = cyc;
    stalled_prev = out_valid && !out_ready;
    held = out_data;
  endtask

  // One clock: drive at posedge+1, check at negedge
  task automatic tick(input logic st, input logic rdy, input logic wra);
    start     = st;
    out_ready = rdy;
    wr_active = wra;
    @(negedge clk);
    if (reset) monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_of(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic wr_of(input int mode, input int k);
    case (mode)
      0: return 1'b0;
      1: return (k >= 2) && (k <= 4);
      default: return ($urandom_range(0, 3) == 0);
    endcase
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                len;
    int                rmode;
    int                wmode;
    int                spur_k;
    int                lat;
  } vec_t;

  vec_t tbl[7];

  task automatic arm(input logic [ADDR_W-1:0] base, input int len);
    exp_q.delete();
    next_addr    = base;
    issues_left  = len;
    issued       = 0;
    popped       = 0;
    cur_len      = len;
    done_cyc     = -1;
    exp_done_cyc = (len == 0) ? cyc + 2 : -1;
    base_addr    = base;
    length       = LEN_W'(len);
  endtask

  task automatic run_burst(input vec_t v);
    int start_cyc;
    start_cyc = cyc;
    arm(v.base, v.len);
    tick(1'b1, ready_of(v.rmode, 0), wr_of(v.wmode, 0));
    base_addr = ADDR_W'($urandom);
    length    = LEN_W'($urandom);
    chk("busy_set", busy == 1'b1, 64'(busy), 64'(1));
    for (int k = 1; k < 400 && done_cyc < 0; k++)
      tick(k == v.spur_k, ready_of(v.rmode, k), wr_of(v.wmode, k));
    chk("done_seen", done_cyc >= 0, 64'(done_cyc), 64'(1));
    chk("all_words", exp_q.size() == 0 && issues_left == 0 && popped == cur_len,
        64'(popped), 64'(cur_len));
    chk("busy_clear", busy == 1'b0, 64'(busy), 64'(0));
    if (v.lat >= 0)
      chk("done_latency", (done_cyc - start_cyc) == v.lat, 64'(done_cyc - start_cyc), 64'(v.lat));
    tick(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{base: 15'h0010, len: 8,  rmode: 0, wmode: 0, spur_k: -1, lat: 11};
    tbl[1] = '{base: 15'h0100, len: 6,  rmode: 1, wmode: 0, spur_k: -1, lat: -1};
    tbl[2] = '{base: 15'h0200, len: 5,  rmode: 0, wmode: 1, spur_k: -1, lat: -1};
    tbl[3] = '{base: 15'h7FFE, len: 4,  rmode: 0, wmode: 0, spur_k: -1, lat: 7};
    tbl[4] = '{base: 15'h1234, len: 0,  rmode: 0, wmode: 0, spur_k: -1, lat: 2};
    tbl[5] = '{base: 15'h0040, len: 7,  rmode: 0, wmode: 0, spur_k: 3,  lat: 10};
    tbl[6] = '{base: 15'h0300, len: 12, rmode: 1, wmode: 2, spur_k: 5,  lat: -1};

    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    wr_active = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_enable", rd_enable == 1'b0, 64'(rd_enable), 64'(0));
    chk("rst_rd_addr",   rd_addr == '0,     64'(rd_addr),   64'(0));
    chk("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'(0));
    chk("rst_out_data",  out_data == '0,    64'(out_data),  64'(0));
    chk("rst_busy",      busy == 1'b0,      64'(busy),      64'(0));
    chk("rst_done",      done == 1'b0,      64'(done),      64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_burst(tbl[i]);

    // Reset in the middle of a 10-word burst after 3 words delivered
    arm(15'h0500, 10);
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 50 && popped < 3; k++) tick(1'b0, 1'b1, 1'b0);
    chk("mid_popped", popped == 3, 64'(popped), 64'(3));
    reset = 1'b0;
    #1;
    chk("mid_rst_outputs",
        rd_enable == 1'b0 && rd_addr == '0 && out_valid == 1'b0 &&
        out_data == '0 && busy == 1'b0 && done == 1'b0,
        {27'b0, rd_enable, out_valid, busy, done, 1'b0, out_data}, 64'(0));
    exp_q.delete();
    issues_left  = 0;
    cur_len      = -1;
    exp_done_cyc = -1;
    stalled_prev = 0;
    @(posedge clk);
    #1;
    tick(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 1'b0);
    chk("post_rst_idle", busy == 1'b0 && out_valid == 1'b0, {62'b0, busy, out_valid}, 64'(0));

    // Random bursts under random backpressure and write activity
    for (int i = 0; i < 25; i++) begin
      rv.base   = ADDR_W'($urandom);
      rv.len    = $urandom_range(0, 20);
      rv.rmode  = 2;
      rv.wmode  = 2;
      rv.spur_k = (rv.len > 0) ? $urandom_range(1, 3) : -1;
      rv.lat    = -1;
      run_burst(rv);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
